// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared mode encodings and step clamp for updown_counter_mod
package updown_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Widest counter the clamp helper serves; callers cast to their own WIDTH.
  localparam int unsigned MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] clamp_step(
    input logic [MAX_WIDTH-1:0] step,
    input logic [MAX_WIDTH-1:0] max_val
  );
    return (step > max_val) ? max_val : step;
  endfunction

endpackage

// File: rtl/updown_counter_next.sv
// rtl/updown_counter_next.sv - combinational next-count, overflow and underflow for one step
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] counter,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] max_val,
  input  logic             up_down,
  input  logic             mode,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf_n,
  output logic             unf_n
);

  // One extra bit keeps max_val+1 and counter+s exact for any WIDTH.
  logic [WIDTH:0] c_x;
  logic [WIDTH:0] s_x;
  logic [WIDTH:0] range_x;
  logic [WIDTH:0] sum_x;

  assign c_x     = {1'b0, counter};
  assign s_x     = {1'b0, s};
  assign range_x = {1'b0, max_val} + {{WIDTH{1'b0}}, 1'b1};
  assign sum_x   = c_x + s_x;

  always_comb begin
    next_count = counter;
    ovf_n      = 1'b0;
    unf_n      = 1'b0;
    if (s != '0) begin
      if (up_down) begin
        if (sum_x < range_x) begin
          next_count = sum_x[WIDTH-1:0];
        end else begin
          ovf_n      = 1'b1;
          next_count = (mode == MODE_SAT) ? max_val : WIDTH'(sum_x - range_x);
        end
      end else begin
        if (c_x >= s_x) begin
          next_count = counter - s;
        end else begin
          unf_n      = 1'b1;
          next_count = (mode == MODE_SAT) ? '0 : WIDTH'(c_x + range_x - s_x);
        end
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - bounded, strided up/down counter with wrap/saturate and event pulses
module updown_counter_mod
  import updown_counter_pkg::*;
#(
  parameter int             WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] max_val,
  input  logic             mode,
  output logic [WIDTH-1:0] counter,
  output logic             ovf,
  output logic             unf,
  output logic             at_max,
  output logic             at_min
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] next_count;
  logic             ovf_n;
  logic             unf_n;

  assign s = WIDTH'(clamp_step(MAX_WIDTH'(step), MAX_WIDTH'(max_val)));

  updown_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .counter    (counter),
    .s          (s),
    .max_val    (max_val),
    .up_down    (up_down),
    .mode       (mode),
    .next_count (next_count),
    .ovf_n      (ovf_n),
    .unf_n      (unf_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= RESET_VAL;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else if (load) begin
      counter <= (load_val > max_val) ? max_val : load_val;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else if (en) begin
      // A bound lowered below the current count snaps to it silently.
      if (counter > max_val) begin
        counter <= max_val;
        ovf     <= 1'b0;
        unf     <= 1'b0;
      end else begin
        counter <= next_count;
        ovf     <= ovf_n;
        unf     <= unf_n;
      end
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end
  end

  assign at_max = (counter == max_val);
  assign at_min = (counter == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - randomized and directed self-checking bench for updown_counter_mod
module tb_updown_counter_mod;

  localparam int W   = 4;
  localparam int RST = 3;

  logic         clk = 1'b0;
  logic         reset, en, up_down, load, mode;
  logic [W-1:0] load_val, step, max_val;
  logic [W-1:0] counter;
  logic         ovf, unf, at_max, at_min;

  int checks = 0;
  int errors = 0;

  int exp_cnt = 0;
  int exp_ovf = 0;
  int exp_unf = 0;

  updown_counter_mod #(
    .WIDTH     (W),
    .RESET_VAL (4'd3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_down  (up_down),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .max_val  (max_val),
    .mode     (mode),
    .counter  (counter),
    .ovf      (ovf),
    .unf      (unf),
    .at_max   (at_max),
    .at_min   (at_min)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour: modular arithmetic on plain integers.
  task automatic model(input int r, input int ld, input int e, input int ud,
                       input int lv, input int st, input int mx, input int md);
    int sc;
    int range;
    sc    = (st < mx) ? st : mx;
    range = mx + 1;
    exp_ovf = 0;
    exp_unf = 0;
    if (r != 0) begin
      exp_cnt = RST;
    end else if (ld != 0) begin
      exp_cnt = (lv < mx) ? lv : mx;
    end else if (e != 0) begin
      if (exp_cnt > mx) begin
        exp_cnt = mx;
      end else if (sc > 0) begin
        if (ud != 0) begin
          if (exp_cnt + sc > mx) begin
            exp_ovf = 1;
            exp_cnt = (md != 0) ? mx : (exp_cnt + sc) % range;
          end else begin
            exp_cnt = exp_cnt + sc;
          end
        end else begin
          if (exp_cnt - sc < 0) begin
            exp_unf = 1;
            exp_cnt = (md != 0) ? 0 : (((exp_cnt - sc) % range) + range) % range;
          end else begin
            exp_cnt = exp_cnt - sc;
          end
        end
      end
    end
  endtask

  task automatic drive(input int r, input int ld, input int e, input int ud,
                       input int lv, input int st, input int mx, input int md);
    reset    = r[0];
    load     = ld[0];
    en       = e[0];
    up_down  = ud[0];
    load_val = lv[W-1:0];
    step     = st[W-1:0];
    max_val  = mx[W-1:0];
    mode     = md[0];
    @(posedge clk);
    model(r, ld, e, ud, lv, st, mx, md);
    #1;
    chk("counter", int'(counter), exp_cnt);
    chk("ovf", int'(ovf), exp_ovf);
    chk("unf", int'(unf), exp_unf);
    chk("at_max", int'(at_max), (exp_cnt == mx) ? 1 : 0);
    chk("at_min", int'(at_min), (exp_cnt == 0) ? 1 : 0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_down = 1'b0; load = 1'b0; mode = 1'b0;
    load_val = '0; step = '0; max_val = '0;

    // Reset then hold
    drive(1, 0, 0, 0, 0, 0, 9, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 0, 1, 9, 0);
      chk("hold_cnt", int'(counter), 3);
      chk("hold_at_max", int'(at_max), 0);
      chk("hold_at_min", int'(at_min), 0);
    end

    // Wrap up: 8 +4 mod 10
    drive(0, 1, 0, 0, 8, 4, 9, 0);
    drive(0, 0, 1, 1, 0, 4, 9, 0);
    chk("wrap_up_cnt", int'(counter), 2);
    chk("wrap_up_ovf", int'(ovf), 1);
    drive(0, 0, 1, 1, 0, 4, 9, 0);
    chk("wrap_up_cnt2", int'(counter), 6);
    chk("wrap_up_ovf2", int'(ovf), 0);

    // Saturate down from 2 by 3
    drive(0, 1, 0, 0, 2, 3, 15, 1);
    drive(0, 0, 1, 0, 0, 3, 15, 1);
    chk("sat_dn_cnt", int'(counter), 0);
    chk("sat_dn_unf", int'(unf), 1);
    drive(0, 0, 1, 0, 0, 3, 15, 1);
    chk("sat_dn_cnt2", int'(counter), 0);
    chk("sat_dn_unf2", int'(unf), 1);
    chk("sat_dn_at_min", int'(at_min), 1);

    // Load priority and clamp, then reset over load
    drive(0, 1, 1, 1, 12, 1, 9, 0);
    chk("load_clamp", int'(counter), 9);
    chk("load_at_max", int'(at_max), 1);
    drive(1, 1, 1, 1, 12, 1, 9, 0);
    chk("reset_over_load", int'(counter), 3);

    // Max lowered at run time
    drive(0, 1, 0, 0, 14, 1, 15, 0);
    drive(0, 0, 1, 1, 0, 1, 5, 0);
    chk("lowered_cnt", int'(counter), 5);
    chk("lowered_ovf", int'(ovf), 0);
    drive(0, 0, 1, 1, 0, 1, 5, 0);
    chk("lowered_wrap", int'(counter), 0);
    chk("lowered_wrap_ovf", int'(ovf), 1);

    // Step clamp and max_val = 0
    drive(0, 1, 0, 0, 1, 15, 3, 0);
    drive(0, 0, 1, 1, 0, 15, 3, 0);
    chk("step_clamp_cnt", int'(counter), 0);
    chk("step_clamp_ovf", int'(ovf), 1);
    drive(0, 0, 1, 1, 0, 15, 0, 0);
    drive(0, 0, 1, 0, 0, 15, 0, 1);
    chk("zero_max_cnt", int'(counter), 0);
    chk("zero_max_unf", int'(unf), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r, ld, e, ud, lv, st, mx, md;
      r  = ($urandom_range(0, 49) == 0) ? 1 : 0;
      ld = ($urandom_range(0, 9) == 0) ? 1 : 0;
      e  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ud = int'($urandom_range(0, 1));
      lv = int'($urandom_range(0, 15));
      st = int'($urandom_range(0, 15));
      mx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      md = int'($urandom_range(0, 1));
      drive(r, ld, e, ud, lv, st, mx, md);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
